// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-wide RAM port between instruction fetch (IF) and the MEM
//   stage. Each 1/2/4-byte access is split into byte cycles, and read bytes are
//   assembled little-endian. stl_mm holds the pipeline while any request is open.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr/if_cancel       fetch request (always 4 bytes), redirect abort
//   if_data/if_done                fetched word and its one-cycle completion pulse
//   mem_req/mem_wr/mem_size        data request, 1=store, size 0=1B 1=2B 2/3=4B
//   mem_addr/mem_wdata             data byte address (any alignment), store data
//   mem_rdata/mem_done             zero-extended load data and completion pulse
//   ram_a/ram_wr/ram_dout/ram_din  RAM byte port; ram_din is one cycle behind ram_a
//   stl_mm                         combinational pipeline stall
//
// state  | meaning
// IDLE   | waiting; MEM request wins over fetch
// IF_RD  | issuing fetch byte addresses and capturing returned bytes
// MEM_RD | same for a load
// MEM_WR | one RAM write per byte
// DONE   | one-cycle completion pulse, then back to IDLE
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   output logic [31:0]       if_data,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_wr,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din,
   output logic              stl_mm
);

   typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

   state_t            state;
   logic [2:0]        cnt;
   logic [2:0]        nbytes;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wbuf;
   logic [31:0]       rbuf;
   logic [31:0]       rbuf_ins;
   logic [7:0]        wbyte_next;
   logic [ADDR_W-1:0] addr_next;
   logic [2:0]        cnt_inc;

   function automatic logic [2:0] size_to_n(input logic [1:0] sz);
      case (sz)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   assign cnt_inc   = cnt + 3'd1;
   assign addr_next = base + ADDR_W'(cnt) + ADDR_W'(1);

   // In read states ram_din carries the byte addressed one cycle earlier,
   // so the byte landing now belongs to index cnt-1.
   always_comb begin
      rbuf_ins = rbuf;
      case (cnt)
         3'd1:    rbuf_ins[7:0]   = ram_din;
         3'd2:    rbuf_ins[15:8]  = ram_din;
         3'd3:    rbuf_ins[23:16] = ram_din;
         3'd4:    rbuf_ins[31:24] = ram_din;
         default: rbuf_ins = rbuf;
      endcase
   end

   always_comb begin
      wbyte_next = 8'h00;
      case (cnt)
         3'd0:    wbyte_next = wbuf[15:8];
         3'd1:    wbyte_next = wbuf[23:16];
         3'd2:    wbyte_next = wbuf[31:24];
         default: wbyte_next = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         nbytes    <= 3'd0;
         base      <= '0;
         wbuf      <= 32'h0;
         rbuf      <= 32'h0;
         ram_a     <= '0;
         ram_wr    <= 1'b0;
         ram_dout  <= 8'h00;
         if_data   <= 32'h0;
         if_done   <= 1'b0;
         mem_rdata <= 32'h0;
         mem_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt  <= 3'd0;
               rbuf <= 32'h0;
               if (mem_req) begin
                  base   <= mem_addr;
                  nbytes <= size_to_n(mem_size);
                  wbuf   <= mem_wdata;
                  ram_a  <= mem_addr;
                  if (mem_wr) begin
                     state    <= MEM_WR;
                     ram_wr   <= 1'b1;
                     ram_dout <= mem_wdata[7:0];
                  end else begin
                     state <= MEM_RD;
                  end
               end else if (if_req && !if_cancel) begin
                  base   <= if_addr;
                  nbytes <= 3'd4;
                  ram_a  <= if_addr;
                  state  <= IF_RD;
               end
            end
            IF_RD, MEM_RD: begin
               if (state == IF_RD && if_cancel) begin
                  state <= IDLE;
               end else begin
                  if (cnt != 3'd0)
                     rbuf <= rbuf_ins;
                  if (cnt == nbytes) begin
                     state <= DONE;
                     if (state == IF_RD) begin
                        if_done <= 1'b1;
                        if_data <= rbuf_ins;
                     end else begin
                        mem_done  <= 1'b1;
                        mem_rdata <= rbuf_ins;
                     end
                  end else begin
                     cnt <= cnt_inc;
                     if (cnt_inc < nbytes)
                        ram_a <= addr_next;
                  end
               end
            end
            MEM_WR: begin
               if (cnt_inc == nbytes) begin
                  ram_wr   <= 1'b0;
                  mem_done <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt      <= cnt_inc;
                  ram_a    <= addr_next;
                  ram_dout <= wbyte_next;
               end
            end
            DONE: begin
               if_done  <= 1'b0;
               mem_done <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Drops in the done cycle so the pipeline advances on that same edge.
   assign stl_mm = ~rst & ((mem_req & ~mem_done) | (if_req & ~if_done & ~if_cancel));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives directed and random fetch/load/store traffic into mem_arbiter with a
//   byte RAM responder. A transaction-level schedule model predicts every output.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_cancel, if_done;
   logic [31:0] if_addr, if_data;
   logic        mem_req, mem_wr, mem_done;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout, ram_din;
   logic        stl_mm;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0] ram  [logic [31:0]];
   logic [7:0] mmem [logic [31:0]];

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .if_data(if_data), .if_done(if_done),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done),
      .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
      .stl_mm(stl_mm)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_b(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : init_b(a);
   endfunction

   function automatic logic [7:0] mrd(input logic [31:0] a);
      return mmem.exists(a) ? mmem[a] : init_b(a);
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] b, input int n);
      logic [31:0] r;
      r = 32'h0;
      for (int k = 0; k < n; k++) r[8*k +: 8] = mrd(b + 32'(k));
      return r;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
      end
   endfunction

   task automatic poke(input logic [31:0] a, input logic [7:0] v);
      ram[a]  = v;
      mmem[a] = v;
   endtask

   // RAM responder: one-cycle read latency
   always @(posedge clk) begin
      ram_din <= ram_rd(ram_a);
      if (ram_wr) ram[ram_a] = ram_dout;
   end

   // Schedule model: once an access is accepted in cycle t0, byte k is addressed
   // in t0+1+k; reads complete at t0+N+2, writes at t0+N+1.
   bit          m_busy = 0;
   int          m_kind = 0;   // 0 fetch, 1 load, 2 store
   int          m_t0 = 0, m_n = 0;
   logic [31:0] m_base = 0, m_wd = 0, m_if_last = 0;
   bit          rst_prev = 1;

   always @(negedge clk) begin : model
      int          rel;
      bit          eifd, emd, ewr, av;
      logic [31:0] ea, edata;
      logic [7:0]  ed;
      eifd = 0; emd = 0; ewr = 0; av = 0; ea = 0; ed = 0; edata = 0;
      rel = cyc - m_t0;
      if (m_busy) begin
         if (m_kind == 2) begin
            if (rel >= 1 && rel <= m_n) begin
               ewr = 1; av = 1;
               ea  = m_base + 32'(rel - 1);
               ed  = m_wd[8*(rel-1) +: 8];
               mmem[ea] = ed;
            end
            if (rel == m_n + 1) emd = 1;
         end else begin
            if (rel >= 1 && rel <= m_n) begin
               av = 1;
               ea = m_base + 32'(rel - 1);
            end
            if (rel == m_n + 2) begin
               if (m_kind == 0) eifd = 1; else emd = 1;
            end
         end
      end
      if (cyc >= 2) begin
         chk("if_done", {31'h0, if_done}, {31'h0, eifd});
         chk("mem_done", {31'h0, mem_done}, {31'h0, emd});
         chk("ram_wr", {31'h0, ram_wr}, {31'h0, ewr});
         chk("stl_mm", {31'h0, stl_mm},
             {31'h0, ~rst & ((mem_req & ~emd) | (if_req & ~eifd & ~if_cancel))});
         if (av) chk("ram_a", ram_a, ea);
         if (ewr) chk("ram_dout", {24'h0, ram_dout}, {24'h0, ed});
         if (eifd) begin
            edata = exp_read(m_base, m_n);
            chk("if_data", if_data, edata);
            m_if_last = edata;
         end
         if (emd && m_kind == 1) chk("mem_rdata", mem_rdata, exp_read(m_base, m_n));
         if (rst_prev) begin
            chk("rst_ram_a", ram_a, 32'h0);
            chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
            chk("rst_if_data", if_data, 32'h0);
            chk("rst_mem_rdata", mem_rdata, 32'h0);
         end else if (!m_busy) begin
            chk("if_data_hold", if_data, m_if_last);
         end
      end
      if (rst) begin
         m_busy = 0;
         m_if_last = 0;
      end else if (m_busy) begin
         if (rel == ((m_kind == 2) ? m_n + 1 : m_n + 2)) m_busy = 0;
         else if (m_kind == 0 && if_cancel) m_busy = 0;
      end else if (mem_req) begin
         m_busy = 1; m_t0 = cyc; m_base = mem_addr; m_wd = mem_wdata;
         m_kind = mem_wr ? 2 : 1;
         m_n    = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
      end else if (if_req && !if_cancel) begin
         m_busy = 1; m_t0 = cyc; m_base = if_addr; m_kind = 0; m_n = 4;
      end
      rst_prev = rst;
   end

   // Called at a drive point (#1 after posedge); element 0 is the first cycle
   // the requests are visible. Done cycles are reported relative to that, -1 if none.
   task automatic run_tx(input bit do_if, input logic [31:0] ia,
                         input bit do_mem, input bit wr, input logic [1:0] sz,
                         input logic [31:0] ma, input logic [31:0] wd,
                         input int cancel_at, input int rst_at,
                         output int if_dc, output int mem_dc,
                         output logic [31:0] ifd, output logic [31:0] md);
      bit fin;
      if_dc = -1; mem_dc = -1; ifd = 0; md = 0; fin = 0;
      if_req = do_if; if_addr = ia;
      mem_req = do_mem; mem_wr = wr; mem_size = sz; mem_addr = ma; mem_wdata = wd;
      for (int e = 0; e < 60 && !fin; e++) begin
         if_cancel = (e == cancel_at);
         rst       = (e == rst_at);
         if (rst) begin
            if_req = 0; mem_req = 0;
         end
         @(negedge clk);
         if (if_done && if_dc < 0) begin if_dc = e; ifd = if_data; end
         if (mem_done && mem_dc < 0) begin mem_dc = e; md = mem_rdata; end
         @(posedge clk); #1;
         if (if_dc >= 0 || (cancel_at >= 0 && e >= cancel_at)) if_req = 0;
         if (mem_dc >= 0) mem_req = 0;
         if (!if_req && !mem_req && e >= cancel_at && e >= rst_at) fin = 1;
      end
      if_cancel = 0;
      rst = 0;
      if (!fin) begin
         n_vec++; n_bad++;
         $display("FAIL timeout cyc=%0d if_req=%0b mem_req=%0b", cyc, if_req, mem_req);
         if_req = 0; mem_req = 0;
         repeat (12) @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      return 32'h0000_1000 + 32'($urandom_range(0, 63));
   endfunction

   initial begin
      int          idc, mdc, sel;
      logic [31:0] ifd, md;
      rst = 1; if_req = 0; if_addr = 0; if_cancel = 0;
      mem_req = 0; mem_wr = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // fetch of 13 05 00 00
      poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
      run_tx(1, 32'h100, 0, 0, 0, 0, 0, -1, -1, idc, mdc, ifd, md);
      chk("t1_done_cyc", 32'(idc), 32'd6);
      chk("t1_if_data", ifd, 32'h0000_0513);

      // simultaneous requests: mem wins, fetch follows
      poke(32'h2003, 8'hFF);
      run_tx(1, 32'h100, 1, 0, 2'd0, 32'h2003, 0, -1, -1, idc, mdc, ifd, md);
      chk("t2_mem_done_cyc", 32'(mdc), 32'd3);
      chk("t2_mem_rdata", md, 32'h0000_00FF);
      chk("t2_if_done_cyc", 32'(idc), 32'd10);

      // 4-byte store
      run_tx(0, 0, 1, 1, 2'd2, 32'h10, 32'hDEAD_BEEF, -1, -1, idc, mdc, ifd, md);
      chk("t3_mem_done_cyc", 32'(mdc), 32'd5);
      chk("t3_ram", {ram_rd(32'h13), ram_rd(32'h12), ram_rd(32'h11), ram_rd(32'h10)}, 32'hDEAD_BEEF);

      // cancelled fetch, then a fresh one
      run_tx(1, 32'h200, 0, 0, 0, 0, 0, 3, -1, idc, mdc, ifd, md);
      chk("t4_no_if_done", 32'(idc), 32'hFFFF_FFFF);
      chk("t4_if_data_kept", if_data, 32'h0000_0513);
      poke(32'h300, 8'hD4); poke(32'h301, 8'hC3); poke(32'h302, 8'hB2); poke(32'h303, 8'hA1);
      run_tx(1, 32'h300, 0, 0, 0, 0, 0, -1, -1, idc, mdc, ifd, md);
      chk("t4_done_cyc", 32'(idc), 32'd6);
      chk("t4_if_data", ifd, 32'hA1B2_C3D4);

      // halfword load wrapping the top of the address space
      poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);
      run_tx(0, 0, 1, 0, 2'd1, 32'hFFFF_FFFF, 0, -1, -1, idc, mdc, ifd, md);
      chk("t5_done_cyc", 32'(mdc), 32'd4);
      chk("t5_mem_rdata", md, 32'h0000_1234);

      // reset in cycle 2 of a store
      run_tx(0, 0, 1, 1, 2'd2, 32'h40, 32'h1122_3344, -1, 2, idc, mdc, ifd, md);
      chk("t6_no_mem_done", 32'(mdc), 32'hFFFF_FFFF);

      for (int t = 0; t < 160; t++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2: run_tx(1, rnd_addr(), 0, 0, 0, 0, 0, -1, -1, idc, mdc, ifd, md);
            3, 4, 5: run_tx(0, 0, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            rnd_addr(), $urandom, -1, -1, idc, mdc, ifd, md);
            6, 7:    run_tx(1, rnd_addr(), 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            rnd_addr(), $urandom, -1, -1, idc, mdc, ifd, md);
            8:       run_tx(1, rnd_addr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            2'($urandom_range(0, 3)), rnd_addr(), $urandom,
                            int'($urandom_range(0, 9)), -1, idc, mdc, ifd, md);
            default: run_tx(1'($urandom_range(0, 1)), rnd_addr(), 1, 1'($urandom_range(0, 1)),
                            2'($urandom_range(0, 3)), rnd_addr(), $urandom,
                            -1, int'($urandom_range(0, 6)), idc, mdc, ifd, md);
         endcase
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
